// File: rtl/fifo_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter_if
// Description : Consumer/FIFO-side signal bundle for the FIFO read-port
//               round-robin arbiter. The arbiter uses the slave modport and
//               its environment uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic         fifo_empty;
  logic         rden;
  logic [N-1:0] gnt;
  logic [N-1:0] rd_valid;
  logic         busy;

  // Consumer / read-pointer-handler side
  modport master (
    output req, lock, fifo_empty,
    input  rden, gnt, rd_valid, busy
  );

  // Arbiter side
  modport slave (
    input  req, lock, fifo_empty,
    output rden, gnt, rd_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_arbiter
// Description : Round-robin arbiter sharing the asynchronous FIFO's single
//               read port among N consumers in the read clock domain. Each
//               grant is bounded to BURST reads; a one-hot rd_valid strobe
//               marks the consumer owning the data one cycle after each read.
//               Optional macro RD_ARB_LOCK_EN lets the owner extend its grant
//               past a burst boundary with lock[owner].
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
  parameter int N     = 4,
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  wire               rdclk,
  input  wire               rdrst,
  fifo_rd_arbiter_if.slave  bus
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_beat_last = CW'(BURST - 1);
  localparam logic [LW-1:0] c_last_rst  = LW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_rd_valid;
  logic [CW-1:0] r_beat;
  logic [LW-1:0] r_last;     // last winner; also the current owner while granted

  logic [LW-1:0] w_pick;
  logic          w_found;
  int            w_idx;
  logic          w_start;
  logic          w_rden;
  logic          w_last_beat;
  logic          w_hold;
  logic          w_release;
  logic          w_unused_lock;

  // Round-robin search: first requester strictly after the last winner, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_found && bus.req[LW'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = LW'(w_idx);
      end
    end
  end

  // Next-state and read-enable decode
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_rden      = 1'b0;
    w_last_beat = 1'b0;
    w_hold      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !bus.fifo_empty) begin
          w_start = 1'b1;
          w_next  = S_GRANT;
        end
      end
      S_GRANT: begin
        w_rden      = bus.req[r_last] & ~bus.fifo_empty;
        w_last_beat = w_rden && (r_beat == c_beat_last);
`ifdef RD_ARB_LOCK_EN
        w_hold      = w_last_beat & bus.lock[r_last];
`else
        w_hold      = 1'b0;
`endif
        // An empty FIFO with the owner still requesting is a stall, not a release
        w_release   = !bus.req[r_last] || (w_last_beat && !w_hold);
        if (w_release) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lock is only consulted when the extension feature is built in
  assign w_unused_lock = ^bus.lock;

  // State, grant, beat counter and delayed data-valid registers
  always_ff @(posedge rdclk or posedge rdrst) begin
    if (rdrst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_beat     <= '0;
      r_last     <= c_last_rst;
    end else begin
      r_state    <= w_next;
      // Read data appears one cycle after rden, so the strobe trails by one
      r_rd_valid <= w_rden ? r_gnt : '0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_gnt         <= '0;
            r_gnt[w_pick] <= 1'b1;
            r_last        <= w_pick;
            r_beat        <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt  <= '0;
            r_beat <= '0;
          end else if (w_rden) begin
            r_beat <= w_hold ? '0 : r_beat + 1'b1;
          end
        end
        default: begin
          r_gnt  <= '0;
          r_beat <= '0;
        end
      endcase
    end
  end

  assign bus.rden     = w_rden;
  assign bus.gnt      = r_gnt;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_arbiter
// Description : Directed self-checking bench for fifo_rd_arbiter (N=4,
//               BURST=4). Inputs change on the falling edge; outputs are
//               sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

  logic rdclk = 1'b0;
  logic rdrst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fifo_rd_arbiter_if #(.N(4)) bus ();

  fifo_rd_arbiter #(.N(4), .BURST(4), .CW(4)) dut (
    .rdclk (rdclk),
    .rdrst (rdrst),
    .bus   (bus.slave)
  );

  always #5 rdclk = ~rdclk;

  task automatic do_reset();
    rdrst          = 1'b1;
    bus.req        = '0;
    bus.lock       = '0;
    bus.fifo_empty = 1'b0;
    @(negedge rdclk);
    @(negedge rdclk);
    rdrst = 1'b0;
  endtask

  task automatic test_reset();
    rdrst          = 1'b1;
    bus.req        = 4'b1111;
    bus.lock       = '0;
    bus.fifo_empty = 1'b0;
    @(negedge rdclk);
    @(negedge rdclk);
    #1;
    total++;
    if ({bus.gnt, bus.rd_valid, bus.busy, bus.rden} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b rdv=%b busy=%b rden=%b want all 0",
               bus.gnt, bus.rd_valid, bus.busy, bus.rden);
    end
  endtask

  task automatic test_single_consumer();
    logic [3:0] eg [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
    logic       er [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] ev [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      @(negedge rdclk);
      #1;
      total++;
      if (bus.gnt !== eg[c] || bus.rden !== er[c] || bus.rd_valid !== ev[c]) begin
        bad++;
        $display("FAIL single c%0d: got gnt=%b rden=%b rdv=%b want gnt=%b rden=%b rdv=%b",
                 c + 1, bus.gnt, bus.rden, bus.rd_valid, eg[c], er[c], ev[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic       exp_r;
    do_reset();
    bus.req = 4'b1111;
    // Each grant: 4 read cycles followed by 1 idle cycle; owners 0,1,2,3,0
    for (int k = 0; k < 25; k++) begin
      @(negedge rdclk);
      #1;
      exp_g = ((k % 5) < 4) ? (4'b0001 << ((k / 5) % 4)) : 4'b0000;
      exp_r = ((k % 5) < 4);
      total++;
      if (bus.gnt !== exp_g || bus.rden !== exp_r || bus.busy !== exp_r) begin
        bad++;
        $display("FAIL round_robin c%0d: got gnt=%b rden=%b busy=%b want gnt=%b rden=%b busy=%b",
                 k + 1, bus.gnt, bus.rden, bus.busy, exp_g, exp_r, exp_r);
      end
    end
  endtask

  task automatic test_stall();
    logic       emp [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [3:0] eg  [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic       er  [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    logic [3:0] ev  [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    int reads = 0;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge rdclk);
      bus.fifo_empty = emp[c];
      #1;
      if (bus.rden === 1'b1) reads++;
      total++;
      if (bus.gnt !== eg[c] || bus.rden !== er[c] || bus.rd_valid !== ev[c]) begin
        bad++;
        $display("FAIL stall c%0d: got gnt=%b rden=%b rdv=%b want gnt=%b rden=%b rdv=%b",
                 c + 1, bus.gnt, bus.rden, bus.rd_valid, eg[c], er[c], ev[c]);
      end
    end
    total++;
    if (reads != 4) begin
      bad++;
      $display("FAIL stall_reads: got %0d want 4", reads);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.req = 4'b0010;
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b0010 || bus.rden !== 1'b1) begin
      bad++;
      $display("FAIL drop_grant: got gnt=%b rden=%b want gnt=0010 rden=1", bus.gnt, bus.rden);
    end
    @(negedge rdclk);
    bus.req = 4'b1001;
    #1;
    total++;
    if (bus.gnt !== 4'b0010 || bus.rden !== 1'b0 || bus.rd_valid !== 4'b0010) begin
      bad++;
      $display("FAIL drop_cycle: got gnt=%b rden=%b rdv=%b want gnt=0010 rden=0 rdv=0010",
               bus.gnt, bus.rden, bus.rd_valid);
    end
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b0000 || bus.rden !== 1'b0 || bus.rd_valid !== 4'b0000) begin
      bad++;
      $display("FAIL drop_idle: got gnt=%b rden=%b rdv=%b want gnt=0000 rden=0 rdv=0000",
               bus.gnt, bus.rden, bus.rd_valid);
    end
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b1000 || bus.rden !== 1'b1) begin
      bad++;
      $display("FAIL drop_next: got gnt=%b rden=%b want gnt=1000 rden=1", bus.gnt, bus.rden);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b1000;
    @(negedge rdclk);
    @(negedge rdclk);
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b1000 || bus.rden !== 1'b1 || bus.rd_valid !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_pre: got gnt=%b rden=%b rdv=%b want gnt=1000 rden=1 rdv=1000",
               bus.gnt, bus.rden, bus.rd_valid);
    end
    bus.req = 4'b1111;
    rdrst   = 1'b1;
    #1;
    total++;
    if ({bus.gnt, bus.rd_valid, bus.busy, bus.rden} !== 10'b0) begin
      bad++;
      $display("FAIL midrst_async: got gnt=%b rdv=%b busy=%b rden=%b want all 0",
               bus.gnt, bus.rd_valid, bus.busy, bus.rden);
    end
    @(negedge rdclk);
    rdrst = 1'b0;
    #1;
    total++;
    if (bus.gnt !== 4'b0000 || bus.rd_valid !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_after: got gnt=%b rdv=%b want gnt=0000 rdv=0000", bus.gnt, bus.rd_valid);
    end
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b0001 || bus.rd_valid !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_regrant: got gnt=%b rdv=%b want gnt=0001 rdv=0000", bus.gnt, bus.rd_valid);
    end
  endtask

  task automatic test_empty_idle();
    do_reset();
    bus.req        = 4'b0001;
    bus.fifo_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge rdclk);
      #1;
      total++;
      if (bus.gnt !== 4'b0000 || bus.rden !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL empty_idle c%0d: got gnt=%b rden=%b busy=%b want 0000 0 0",
                 c + 1, bus.gnt, bus.rden, bus.busy);
      end
    end
    bus.fifo_empty = 1'b0;
    @(negedge rdclk);
    #1;
    total++;
    if (bus.gnt !== 4'b0001 || bus.rden !== 1'b1) begin
      bad++;
      $display("FAIL empty_release: got gnt=%b rden=%b want gnt=0001 rden=1", bus.gnt, bus.rden);
    end
  endtask

`ifdef RD_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g;
    do_reset();
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    // 12 back-to-back reads for consumer 0, one idle cycle, then consumer 1
    for (int c = 1; c <= 14; c++) begin
      @(negedge rdclk);
      if (c == 9) bus.lock = 4'b0000;
      #1;
      exp_g = (c <= 12) ? 4'b0001 : ((c == 13) ? 4'b0000 : 4'b0010);
      total++;
      if (bus.gnt !== exp_g || bus.rden !== (c != 13)) begin
        bad++;
        $display("FAIL lock c%0d: got gnt=%b rden=%b want gnt=%b rden=%b",
                 c, bus.gnt, bus.rden, exp_g, (c != 13));
      end
    end
  endtask
`endif

  initial begin
    bus.req        = '0;
    bus.lock       = '0;
    bus.fifo_empty = 1'b0;
    test_reset();
    test_single_consumer();
    test_round_robin();
    test_stall();
    test_early_drop();
    test_reset_mid_burst();
    test_empty_idle();
`ifdef RD_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
